// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronized edge-latched sources, mask,
// fixed lowest-index priority and a REQ/SERVICE/EOI handshake.
module intr_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [NSRC-1:0] irq_in,
    output logic            intr,
    input  logic            inta,
    input  logic            io_sel,
    input  logic [3:0]      io_addr,
    input  logic            io_we,
    input  logic [31:0]     io_wdata,
    output logic [31:0]     io_rdata,
    output logic [2:0]      irq_id,
    output logic            in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [NSRC-1:0] sync1, sync2, prev;
    logic [NSRC-1:0] pending, mask;
    logic [NSRC-1:0] active, rise, ack_clr, w1c;
    logic [2:0]      winner;
    logic            wr, take;

    assign wr     = io_sel & io_we;
    assign active = pending & mask;
    assign rise   = sync2 & ~prev;
    assign take   = (state == REQ) && inta && (|active);
    assign w1c    = (wr && io_addr == 4'h0) ? io_wdata[NSRC-1:0] : '0;

    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) winner = 3'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        if (take) ack_clr[winner] = 1'b1;
    end

    // A fresh edge always wins over W1C or ack clear of the same bit.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            sync1   <= irq_in;
            sync2   <= sync1;
            prev    <= sync2;
            pending <= (pending & ~w1c & ~ack_clr) | rise;
            if (wr && io_addr == 4'h1) mask <= io_wdata[NSRC-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= IDLE;
            irq_id <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|active) state <= REQ;
                end
                REQ: begin
                    if (take) begin
                        irq_id <= winner;
                        state  <= SERVICE;
                    end else if (!(|active)) begin
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (wr && io_addr == 4'h3) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign intr       = (state == REQ);
    assign in_service = (state == SERVICE);

    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            case (io_addr)
                4'h0: io_rdata[NSRC-1:0] = pending;
                4'h1: io_rdata[NSRC-1:0] = mask;
                4'h2: io_rdata = {in_service, 28'b0, irq_id};
                4'h4: io_rdata[1:0] = state;
                default: io_rdata = '0;
            endcase
        end
    end

endmodule
